// File: rtl/vector_lane_packer.sv
`default_nettype none
// ============================================================================
// Module      : vector_lane_packer
// Description : Collects `lanes` scalar elements into one vector register write.
//               Optional macro PACK_FLUSH_EN adds a FLUSH input that commits a
//               partially filled vector early.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_lane_packer #(
  parameter int bits  = 16,
  parameter int lanes = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        dest,
  input  logic                        s_valid,
  input  logic [bits-1:0]             s_data,
`ifdef PACK_FLUSH_EN
  input  logic                        flush,
`endif
  output logic                        s_ready,
  output logic                        we3,
  output logic                        v3,
  output logic [lanes-1:0][bits-1:0]  wd3,
  output logic                        busy,
  output logic                        done
);

  localparam int            CW        = (lanes > 1) ? $clog2(lanes) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(lanes - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [CW-1:0]             cnt_q,   cnt_d;
  logic [lanes-1:0][bits-1:0] buf_q,  buf_d;
  logic                      dest_q,  dest_d;
  logic                      accept;

  assign accept = (state_q == FILL) && s_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    dest_d  = dest_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dest_d  = dest;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          buf_d[cnt_q] = s_data;
          if (cnt_q == LAST_LANE) begin
            cnt_d   = '0;
            state_d = COMMIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef PACK_FLUSH_EN
        // A zero counter with no accept this cycle means nothing was stored.
        if (flush) begin
          if (accept || (cnt_q != '0)) state_d = COMMIT;
          else                         state_d = IDLE;
        end
`endif
      end
      COMMIT: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      dest_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      dest_q  <= dest_d;
    end
  end

  assign s_ready = (state_q == FILL);
  assign we3     = (state_q == COMMIT);
  assign done    = (state_q == COMMIT);
  assign busy    = (state_q == FILL) || (state_q == COMMIT);
  assign v3      = dest_q;
  assign wd3     = buf_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_lane_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_lane_packer
// Description : Self-checking bench for vector_lane_packer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_lane_packer;

  localparam int B = 16;
  localparam int L = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 dest = 1'b0;
  logic                 s_valid = 1'b0;
  logic [B-1:0]         s_data = '0;
`ifdef PACK_FLUSH_EN
  logic                 flush = 1'b0;
`endif
  logic                 s_ready, we3, v3, busy, done;
  logic [L-1:0][B-1:0]  wd3;

  int checks = 0;
  int errors = 0;

  logic [B-1:0] pkt [L];
  logic [B-1:0] model_q [$];

  always #5 clk = ~clk;

  vector_lane_packer #(.bits(B), .lanes(L)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .dest    (dest),
    .s_valid (s_valid),
    .s_data  (s_data),
`ifdef PACK_FLUSH_EN
    .flush   (flush),
`endif
    .s_ready (s_ready),
    .we3     (we3),
    .v3      (v3),
    .wd3     (wd3),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected write data: accepted elements in order, remaining lanes zero.
  function automatic logic [L-1:0][B-1:0] expected_vec();
    logic [L-1:0][B-1:0] v;
    v = '0;
    for (int i = 0; i < L; i++)
      if (i < model_q.size()) v[i] = model_q[i];
    return v;
  endfunction

  // mode 0: valid every cycle, 1: valid toggles 1/0, 2: random gaps
  task automatic run_vector(input logic d, input int mode, input bit poke_start, input string tag);
    int acc;
    int cyc;
    logic vld;
    logic [L-1:0][B-1:0] exp_v;
    acc = 0;
    cyc = 0;
    model_q.delete();
    start = 1'b1; dest = d; s_valid = 1'b0;
    tick();
    start = 1'b0; dest = ~d;
    while (acc < L && cyc < 20 * L) begin
      checks++;
      if (s_ready !== 1'b1 || busy !== 1'b1 || we3 !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s fill_status cyc %0d: got s_ready=%b busy=%b we3=%b done=%b, want 1 1 0 0",
                 tag, cyc, s_ready, busy, we3, done);
        break;
      end
      case (mode)
        0:       vld = 1'b1;
        1:       vld = (cyc % 2 == 0);
        default: vld = ($urandom_range(0, 2) != 0);
      endcase
      s_valid = vld;
      s_data  = vld ? pkt[acc] : B'($urandom);
      if (poke_start) begin
        start = 1'($urandom_range(0, 1));
        dest  = ~d;
      end
      tick();
      if (vld) begin
        model_q.push_back(pkt[acc]);
        acc++;
      end
      cyc++;
    end
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = B'($urandom);
    exp_v   = expected_vec();
    checks++;
    if (we3 !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL %s commit_pulse: got we3=%b done=%b, want 1 1", tag, we3, done);
    end
    checks++;
    if (v3 !== d) begin
      errors++;
      $display("FAIL %s commit_v3: got %b, want %b", tag, v3, d);
    end
    checks++;
    if (wd3 !== exp_v) begin
      errors++;
      $display("FAIL %s commit_wd3: got %h, want %h", tag, wd3, exp_v);
    end
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s commit_status: got s_ready=%b busy=%b, want 0 1", tag, s_ready, busy);
    end
    tick();
    checks++;
    if (we3 !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_status: got we3=%b done=%b busy=%b s_ready=%b, want 0 0 0 0",
               tag, we3, done, busy, s_ready);
    end
    checks++;
    if (v3 !== d || wd3 !== exp_v) begin
      errors++;
      $display("FAIL %s idle_hold: got v3=%b wd3=%h, want v3=%b wd3=%h", tag, v3, wd3, d, exp_v);
    end
    tick();
    s_valid = 1'b0;
    checks++;
    if (we3 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_second: got we3=%b busy=%b, want 0 0", tag, we3, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (s_ready !== 1'b0 || we3 !== 1'b0 || v3 !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || wd3 !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got s_ready=%b we3=%b v3=%b busy=%b done=%b wd3=%h, want all 0",
               s_ready, we3, v3, busy, done, wd3);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < L; i++) pkt[i] = B'(i + 1);
    run_vector(1'b1, 0, 1'b0, "seq");
  endtask

  task automatic test_toggle();
    for (int i = 0; i < L; i++) pkt[i] = B'(16'hA000 + i);
    run_vector(1'b0, 1, 1'b0, "toggle");
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < L; i++) pkt[i] = B'($urandom);
    run_vector(1'b0, 2, 1'b1, "start_ign");
  endtask

  task automatic test_reset_mid();
    start = 1'b1; dest = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = B'(16'h5A00 + i + 1);
      tick();
    end
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b0 || we3 !== 1'b0 || v3 !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || wd3 !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got s_ready=%b we3=%b v3=%b busy=%b done=%b wd3=%h, want all 0",
               s_ready, we3, v3, busy, done, wd3);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (we3 !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet cyc %0d: got we3=%b busy=%b, want 0 0", c, we3, busy);
      end
    end
    for (int i = 0; i < L; i++) pkt[i] = 16'h1111;
    run_vector(1'b0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < L; i++) pkt[i] = B'($urandom);
      run_vector(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), "random");
    end
  endtask

`ifdef PACK_FLUSH_EN
  task automatic test_flush();
    logic [L-1:0][B-1:0] exp_v;
    // Two elements, then flush on an idle-valid cycle
    model_q.delete();
    start = 1'b1; dest = 1'b1;
    tick();
    start = 1'b0;
    s_valid = 1'b1; s_data = 16'hBEEF; tick(); model_q.push_back(16'hBEEF);
    s_valid = 1'b1; s_data = 16'hCAFE; tick(); model_q.push_back(16'hCAFE);
    s_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_v = expected_vec();
    checks++;
    if (we3 !== 1'b1 || done !== 1'b1 || v3 !== 1'b1 || wd3 !== exp_v) begin
      errors++;
      $display("FAIL flush_two: got we3=%b done=%b v3=%b wd3=%h, want 1 1 1 %h", we3, done, v3, wd3, exp_v);
    end
    tick();
    // Flush in the same cycle as the first accept
    model_q.delete();
    start = 1'b1; dest = 1'b0;
    tick();
    start = 1'b0;
    s_valid = 1'b1; s_data = 16'h1234; flush = 1'b1;
    tick();
    model_q.push_back(16'h1234);
    s_valid = 1'b0; flush = 1'b0;
    exp_v = expected_vec();
    checks++;
    if (we3 !== 1'b1 || v3 !== 1'b0 || wd3 !== exp_v) begin
      errors++;
      $display("FAIL flush_same_cycle: got we3=%b v3=%b wd3=%h, want 1 0 %h", we3, v3, wd3, exp_v);
    end
    tick();
    // Flush with nothing stored abandons the vector
    start = 1'b1; dest = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || we3 !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: got busy=%b s_ready=%b we3=%b done=%b, want 0 0 0 0", busy, s_ready, we3, done);
    end
    // Flush in IDLE does nothing
    flush = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (we3 !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL flush_idle cyc %0d: got we3=%b busy=%b, want 0 0", c, we3, busy);
      end
    end
    flush = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_toggle();
    test_start_ignored();
    test_reset_mid();
    test_random();
`ifdef PACK_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
